arb_rr_seq: RTL and testbench

Registered, parametrised request arbiter; next generation of the 16-bit combinational lowest-index-first arbiter. Supports fixed-priority and round-robin modes, holds a grant until release, and enforces a hold-time limit. Sits in front of shared ALU/result-bus resources, turning N request lines into one registered one-hot grant plus encoded index.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/prio_pick_lsb.sv | 17 +
 rtl/arb_rr_seq.sv | 139 +++++++++++++
 tb/tb_arb_rr_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the registered request arbiter.
//   state_t  : arbiter FSM states (IDLE = no grant, BUSY = grant held)
//   idx_w()  : index width for N requesters ($clog2(N), never below 1)
//   oh2idx() : one-hot vector (up to MAX_N bits) to binary index
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int MAX_N = 64;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // OR-reduction of set-bit positions; exact for a one-hot input, 0 for all-zero.
   function automatic logic [5:0] oh2idx(input logic [MAX_N-1:0] oh);
      logic [5:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) idx = idx | 6'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/prio_pick_lsb.sv
// Combinational lowest-set-bit picker.
//   req_i : request vector
//   oh_o  : one-hot of the lowest set bit of req_i (all-zero when req_i == 0)
//   any_o : at least one request present
module prio_pick_lsb #(
   parameter int N = 16
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] oh_o,
   output logic         any_o
);

   // Two's-complement trick isolates the lowest set bit.
   assign oh_o  = req_i & (~req_i + N'(1));
   assign any_o = |req_i;

endmodule

// File: rtl/arb_rr_seq.sv
// Registered N-way request arbiter with fixed-priority / round-robin modes,
// grant hold until release, and an optional hold-time limit.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   r    : request vector, bit i = requester i
//   mode : 0 = fixed priority (bit 0 highest), 1 = round-robin from ptr
//   done : current grantee releases its grant this cycle
//   g    : registered one-hot grant, all-zero when idle
//   gv   : grant valid
//   gidx : index of the granted bit, 0 when idle
module arb_rr_seq
   import arb_pkg::*;
#(
   parameter int  N       = 16,
   parameter int  MAXHOLD = 8,
   localparam int IW      = idx_w(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  r,
   input  logic          mode,
   input  logic          done,
   output logic [N-1:0]  g,
   output logic          gv,
   output logic [IW-1:0] gidx
);

   localparam int            CW        = $clog2(MAXHOLD + 2);
   localparam logic [CW-1:0] HOLD_MAX  = CW'(MAXHOLD);
   localparam logic [CW-1:0] HOLD_LAST = CW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
   localparam logic [N-1:0]  ONES      = '1;

   state_t        state_q, state_d;
   logic [N-1:0]  g_q, g_d;
   logic          gv_q, gv_d;
   logic [IW-1:0] gidx_q, gidx_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          forced, rel;
   logic [IW-1:0] ptr_nxt, ptr_arb;
   logic [N-1:0]  req_arb, req_ge, m_oh, a_oh, win_oh;
   logic          m_any, a_any;

   // cnt_q counts holding edges after the grant edge, so the grant is visible
   // for exactly MAXHOLD cycles before the forced release edge.
   assign forced  = (MAXHOLD != 0) && (cnt_q >= HOLD_LAST);
   assign rel     = (state_q == BUSY) && (done || !r[gidx_q] || forced);
   assign ptr_nxt = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

   // On release the outgoing grantee is masked out and the search starts just
   // past it, so the back-to-back grant already uses the advanced pointer.
   assign ptr_arb = rel ? ptr_nxt : ptr_q;
   assign req_arb = rel ? (r & ~g_q) : r;
   assign req_ge  = req_arb & (ONES << ptr_arb);

   prio_pick_lsb #(.N(N)) u_pick_ge (
      .req_i (req_ge),
      .oh_o  (m_oh),
      .any_o (m_any)
   );

   prio_pick_lsb #(.N(N)) u_pick_all (
      .req_i (req_arb),
      .oh_o  (a_oh),
      .any_o (a_any)
   );

   // Round-robin wraps to the overall lowest request when nothing sits at/above ptr.
   assign win_oh = (mode && m_any) ? m_oh : a_oh;

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      gv_d    = gv_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (a_any) begin
               state_d = BUSY;
               g_d     = win_oh;
               gv_d    = 1'b1;
               gidx_d  = IW'(oh2idx(MAX_N'(win_oh)));
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (rel) begin
               ptr_d = ptr_nxt;
               cnt_d = '0;
               if (a_any) begin
                  g_d    = win_oh;
                  gv_d   = 1'b1;
                  gidx_d = IW'(oh2idx(MAX_N'(win_oh)));
               end else begin
                  state_d = IDLE;
                  g_d     = '0;
                  gv_d    = 1'b0;
                  gidx_d  = '0;
               end
            end else if (cnt_q != HOLD_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            g_d     = '0;
            gv_d    = 1'b0;
            gidx_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         gv_q    <= 1'b0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         gv_q    <= gv_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign g    = g_q;
   assign gv   = gv_q;
   assign gidx = gidx_q;

endmodule

// File: tb/tb_arb_rr_seq.sv
module tb_arb_rr_seq;

   localparam int NR   = 16;
   localparam int MAXH = 8;

   logic            clk;
   logic            rst;
   logic [NR-1:0]   r;
   logic            mode;
   logic            done;
   logic [NR-1:0]   g;
   logic            gv;
   logic [3:0]      gidx;

   int checks = 0;
   int fails  = 0;

   typedef struct packed {
      logic [NR-1:0] g;
      logic          gv;
      logic [3:0]    gidx;
   } exp_t;

   exp_t exp_q[$];

   arb_rr_seq #(.N(NR), .MAXHOLD(MAXH)) dut (
      .clk  (clk),
      .rst  (rst),
      .r    (r),
      .mode (mode),
      .done (done),
      .g    (g),
      .gv   (gv),
      .gidx (gidx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: walk candidates in priority order; round-robin starts at p.
   function automatic int pick(input logic [NR-1:0] req, input bit m, input int p, input int excl);
      for (int k = 0; k < NR; k++) begin
         int i;
         i = m ? (p + k) % NR : k;
         if (req[i] && i != excl) return i;
      end
      return -1;
   endfunction

   // Behavioural model: steps at each active edge and queues the outputs expected after it.
   initial begin
      int busy, cur, ptr, held, w;
      exp_t e;
      busy = 0; cur = 0; ptr = 0; held = 0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            busy = 0; cur = 0; ptr = 0; held = 0;
         end else begin
            if (busy == 0) begin
               w = pick(r, mode, ptr, -1);
               if (w >= 0) begin busy = 1; cur = w; held = 1; end
            end else if (done || !r[cur] || (MAXH != 0 && held >= MAXH)) begin
               ptr = (cur + 1) % NR;
               w = pick(r, mode, ptr, cur);
               if (w >= 0) begin cur = w; held = 1; end
               else begin busy = 0; cur = 0; end
            end else begin
               held++;
            end
            e.g    = busy ? (NR'(1) << cur) : '0;
            e.gv   = (busy != 0);
            e.gidx = busy ? 4'(cur) : 4'd0;
            exp_q.push_back(e);
         end
      end
   end

   // Monitor: compares DUT outputs against the queued expectation each cycle.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_g",    32'(g),    32'(e.g));
         chk("sb_gv",   32'(gv),   32'(e.gv));
         chk("sb_gidx", 32'(gidx), 32'(e.gidx));
      end
   end

   task automatic step(input logic [NR-1:0] rr, input logic m, input logic d);
      @(negedge clk);
      r = rr; mode = m; done = d;
      @(posedge clk);
      #2;
   endtask

   task automatic expect_g(input string nm, input logic [NR-1:0] eg);
      logic [3:0] ei;
      ei = '0;
      for (int i = 0; i < NR; i++) if (eg[i]) ei = 4'(i);
      chk({nm, "_g"},    32'(g),    32'(eg));
      chk({nm, "_gv"},   32'(gv),   32'(eg != '0));
      chk({nm, "_gidx"}, 32'(gidx), 32'(ei));
   endtask

   initial begin
      rst = 1'b1; r = '0; mode = 1'b0; done = 1'b0;
      repeat (3) @(negedge clk);
      expect_g("reset", 16'h0000);
      rst = 1'b0;

      // Round-robin wrap between requesters 0 and 15
      step(16'h8001, 1'b1, 1'b0); expect_g("rr0", 16'h0001);
      step(16'h8001, 1'b1, 1'b1); expect_g("rr1", 16'h8000);
      step(16'h8001, 1'b1, 1'b1); expect_g("rr2", 16'h0001);
      step(16'h8001, 1'b1, 1'b1); expect_g("rr3", 16'h8000);

      // Fixed priority, served requesters drop out
      step(16'h00A4, 1'b0, 1'b0); expect_g("fp0", 16'h0004);
      step(16'h00A0, 1'b0, 1'b1); expect_g("fp1", 16'h0020);
      step(16'h0080, 1'b0, 1'b1); expect_g("fp2", 16'h0080);

      // Hold limit
      step(16'h0000, 1'b0, 1'b0); expect_g("idle", 16'h0000);
      for (int i = 0; i < MAXH; i++) begin
         step(16'h0003, 1'b0, 1'b0); expect_g("hold", 16'h0001);
      end
      step(16'h0003, 1'b0, 1'b0); expect_g("hold_end", 16'h0002);

      // Request drop and empty
      step(16'h0008, 1'b0, 1'b0); expect_g("drop0", 16'h0008);
      step(16'h0000, 1'b0, 1'b0); expect_g("drop1", 16'h0000);
      for (int i = 0; i < 10; i++) begin
         step(16'h0000, 1'b0, 1'b0); expect_g("empty", 16'h0000);
      end

      // Simultaneous done + new request; done while idle
      step(16'h0001, 1'b0, 1'b0); expect_g("sim0", 16'h0001);
      step(16'h0003, 1'b0, 1'b1); expect_g("sim1", 16'h0002);
      step(16'h0000, 1'b0, 1'b0); expect_g("sim2", 16'h0000);
      step(16'h0000, 1'b0, 1'b1); expect_g("idle_done", 16'h0000);
      step(16'h0004, 1'b0, 1'b1); expect_g("idle_done_req", 16'h0004);

      // Async reset mid-grant, then first grant from ptr = 0
      step(16'hFFFF, 1'b1, 1'b0);
      step(16'hFFFF, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      expect_g("async_rst", 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #2;
      expect_g("post_rst", 16'h0001);

      // Randomised traffic checked by the scoreboard
      for (int i = 0; i < 600; i++) begin
         logic [NR-1:0] rr;
         logic          m;
         rr = NR'($urandom) & NR'($urandom);
         if ($urandom_range(0, 9) == 0) rr = '0;
         m = (((i / 50) % 2) == 1) ^ ($urandom_range(0, 19) == 0);
         step(rr, m, ($urandom_range(0, 3) == 0));
      end

      step(16'h0000, 1'b0, 1'b0);
      step(16'h0000, 1'b0, 1'b0);
      expect_g("final_idle", 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
